// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file writeback controller.
package rf_ctrl_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_ID_W = 4;
  localparam int NUM_REGS = 16;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = 3;

  // Requester slots on the round-robin arbiter.
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  // Round-robin pointer: names the requester that wins the next tie.
  typedef enum logic {
    PTR_ALU = 1'b0,
    PTR_MEM = 1'b1
  } rr_ptr_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// 2-way round-robin arbiter (ALU / memory-load writeback).
// Handshake: a requester holds valid independent of ready; a transfer happens on
// any clock edge where valid && grant are both high. Because valid is never gated
// on grant, every grant is an accept, so the pointer advances on any grant.
// Pointer state is observable as ptr_q inside this module.
import rf_ctrl_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  rr_ptr_t ptr_q;
  rr_ptr_t ptr_next;

  // Pointer register: reset favours the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PTR_ALU;
    end else begin
      ptr_q <= ptr_next;
    end
  end

  // Grant selection and pointer update: pointer moves to the non-winner after an accept.
  always_comb begin
    grant    = 2'b00;
    ptr_next = ptr_q;
    if (req[REQ_ALU] && req[REQ_MEM]) begin
      if (ptr_q == PTR_ALU) begin
        grant[REQ_ALU] = 1'b1;
      end else begin
        grant[REQ_MEM] = 1'b1;
      end
    end else if (req[REQ_ALU]) begin
      grant[REQ_ALU] = 1'b1;
    end else if (req[REQ_MEM]) begin
      grant[REQ_MEM] = 1'b1;
    end
    if (grant[REQ_ALU]) begin
      ptr_next = PTR_MEM;
    end else if (grant[REQ_MEM]) begin
      ptr_next = PTR_ALU;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback controller for the 16x16 register file's single write port.
// Round-robin arbitrates ALU and load writebacks, registers the winner onto the
// register file write port one cycle after accept, and tracks per-register
// outstanding writes (reserve at issue, retire at writeback accept) for RAW stalls.
// Optional macro RF_WB_FORWARD_EN adds src1_id/src2_id inputs and fwd1_hit/fwd2_hit
// outputs flagging that the in-flight write targets a decode source operand.
import rf_ctrl_pkg::*;

module rf_wb_arbiter #(
  parameter int DATA_W   = rf_ctrl_pkg::DATA_W,
  parameter int REG_ID_W = rf_ctrl_pkg::REG_ID_W,
  parameter int CNT_W    = rf_ctrl_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [REG_ID_W-1:0] alu_dst,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [REG_ID_W-1:0] mem_dst,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                rsv_valid,
  output logic                rsv_ready,
  input  logic [REG_ID_W-1:0] rsv_dst,
  output logic                rf_write,
  output logic [REG_ID_W-1:0] rf_dst,
  output logic [DATA_W-1:0]   rf_data,
  output logic [NUM_REGS-1:0] busy,
`ifdef RF_WB_FORWARD_EN
  input  logic [REG_ID_W-1:0] src1_id,
  input  logic [REG_ID_W-1:0] src2_id,
  output logic                fwd1_hit,
  output logic                fwd2_hit,
`endif
  output logic                err_underflow
);

  logic [1:0]          req;
  logic [1:0]          grant;
  logic                accept;
  logic [REG_ID_W-1:0] win_dst;
  logic [DATA_W-1:0]   win_data;
  logic                rsv_fire;
  logic                ret_fire;
  logic [NUM_REGS-1:0] inc_sel;
  logic [NUM_REGS-1:0] dec_sel;
  logic [NUM_REGS-1:0] busy_next;
  logic                underflow_set;
  logic [CNT_W-1:0]    count      [NUM_REGS];
  logic [CNT_W-1:0]    count_next [NUM_REGS];

  assign req[REQ_ALU] = alu_valid;
  assign req[REQ_MEM] = mem_valid;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant)
  );

  assign alu_ready = grant[REQ_ALU];
  assign mem_ready = grant[REQ_MEM];
  assign accept    = |grant;
  assign win_dst   = grant[REQ_MEM] ? mem_dst  : alu_dst;
  assign win_data  = grant[REQ_MEM] ? mem_data : alu_data;

  // Register 0 is hardwired: its writes are accepted but never reach the file or the scoreboard.
  assign ret_fire  = accept && (win_dst != '0);
  assign rsv_ready = (rsv_dst == '0) || (count[rsv_dst] != CNT_W'(CNT_MAX));
  assign rsv_fire  = rsv_valid && rsv_ready && (rsv_dst != '0);

  // Decode reserve/retire into one-hot per-register strobes.
  always_comb begin
    inc_sel = '0;
    dec_sel = '0;
    if (rsv_fire) inc_sel[rsv_dst] = 1'b1;
    if (ret_fire) dec_sel[win_dst] = 1'b1;
  end

  // Next counter values: reserve+retire on the same register cancel; retire at zero holds and flags.
  always_comb begin
    underflow_set = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      count_next[i] = count[i];
      if (inc_sel[i] && !dec_sel[i]) begin
        count_next[i] = count[i] + CNT_W'(1);
      end else if (dec_sel[i] && !inc_sel[i]) begin
        if (count[i] == '0) begin
          underflow_set = 1'b1;
        end else begin
          count_next[i] = count[i] - CNT_W'(1);
        end
      end
      busy_next[i] = (count_next[i] != '0);
    end
  end

  // Scoreboard state, registered busy vector and sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) count[i] <= '0;
      busy          <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) count[i] <= count_next[i];
      busy          <= busy_next;
      err_underflow <= err_underflow | underflow_set;
    end
  end

  // Register file write port: one cycle after accept, one write per accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write <= 1'b0;
      rf_dst   <= '0;
      rf_data  <= '0;
    end else begin
      rf_write <= ret_fire;
      if (accept) begin
        rf_dst  <= win_dst;
        rf_data <= win_data;
      end
    end
  end

`ifdef RF_WB_FORWARD_EN
  assign fwd1_hit = rf_write && (rf_dst == src1_id) && (src1_id != '0);
  assign fwd2_hit = rf_write && (rf_dst == src2_id) && (src2_id != '0);
`endif

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Writeback controller for the 16x16 register file's single write port.
- Arbitrates round-robin between the ALU and memory-load writeback requesters using valid/ready handshakes.
- Registers the winning write onto the register file's DstReg/WriteReg/DstData inputs.
- Keeps a per-register outstanding-write scoreboard so the issue stage can stall on RAW hazards.

Parameters:
- DATA_W, 16, register data width.
- REG_ID_W, 4, register index width (16 registers).
- CNT_W, 2, width of the per-register outstanding-write counter (saturates at 3).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_dst  in  REG_ID_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load writeback request
- mem_ready  out  1  load request accepted this cycle
- mem_dst  in  REG_ID_W  load destination register
- mem_data  in  DATA_W  load data
- rsv_valid  in  1  issue stage reserves a destination
- rsv_ready  out  1  reservation accepted
- rsv_dst  in  REG_ID_W  register being reserved
- rf_write  out  1  to register file WriteReg
- rf_dst  out  REG_ID_W  to register file DstReg
- rf_data  out  DATA_W  to register file DstData
- busy  out  16  bit i = register i has outstanding writes
- err_underflow  out  1  sticky: write retired to a register with count 0

Behaviour:
- Reset (async, immediate):
  - rf_write=0, rf_dst=0, rf_data=0.
  - All counters=0, so busy=0.
  - err_underflow=0.
  - Round-robin pointer set to ALU.
  - A write accepted in the cycle reset asserts is discarded.
- Arbitration (combinational ready; requester inputs never gate themselves on ready):
  - Only one valid requester: it gets ready=1.
  - Both valid: the one the pointer names wins.
  - Pointer moves to the non-winner after every accept; it is unchanged when nothing is accepted.
  - Neither requester can be starved for more than 1 cycle.
- Write latency: accept in cycle N -> rf_write=1 with that dst/data in cycle N+1. The register file commits on edge N+2, so the new value is readable in cycle N+2.
- rf_write stays high only for cycles following an accept; back-to-back accepts give continuous writes.
- Register 0 writes:
  - Accepted (ready behaves normally) but rf_write=0 in cycle N+1.
  - Counter for register 0 untouched.
- Reservations:
  - rsv_ready = (rsv_dst==0) or count[rsv_dst] != 3.
  - Accept increments count[rsv_dst]; rsv_dst==0 is accepted with no effect.
- Retire: an accepted write decrements count[dst] at accept time (edge N+1).
- Same-cycle reserve and retire of the same register: net change 0; rsv_ready uses the pre-edge count.
- Retire when count==0: count stays 0 (no wrap) and err_underflow latches 1 until reset.
- busy[i] = (count[i] != 0), registered; busy[0] always 0.

Optional Feature:
- Macro: RF_WB_FORWARD_EN.
- Defined:
  - Adds inputs src1_id and src2_id (REG_ID_W each) and outputs fwd1_hit and fwd2_hit (1 each).
  - fwdK_hit = rf_write && rf_dst==srcK_id && srcK_id!=0, evaluated combinationally.
  - The decode stage then muxes in rf_data, covering the cycle before the register file commits.
- Not defined: these ports are absent and there is no forwarding logic.

Decomposition:
- Package rf_ctrl_pkg holds:
  - DATA_W, REG_ID_W, NUM_REGS=16, CNT_MAX=3.
  - Requester index constants REQ_ALU=0 and REQ_MEM=1.
- One sub-module, rr_arb2: 2-way round-robin arbiter with valid inputs, grant outputs, accept-driven pointer flop and async reset.
- Scoreboard counters stay inline.

Test Plan:
- Single write: alu_valid with dst=4'hA, data=16'hFACE held 1 cycle -> alu_ready=1 that cycle; next cycle rf_write=1, rf_dst=A, rf_data=FACE; following cycle rf_write=0.
- Contention: alu and mem both valid for 4 cycles after reset (alu dst=1, data 1111; mem dst=2, data 2222) -> grants ALU, MEM, ALU, MEM; rf_dst sequence 1,2,1,2.
- Scoreboard: reserve r5 three times -> busy[5]=1 and rsv_ready=0 for a 4th r5 reserve; one mem write to r5 -> count=2 and rsv_ready=1; two more writes -> busy[5]=0.
- Same-cycle reserve and retire on r3 with count=1 -> count stays 1, busy[3]=1; then a write to r7 with count 0 -> err_underflow=1 and stays 1.
- r0 handling: alu write dst=0, data=2222 -> alu_ready=1, rf_write stays 0; reserve r0 -> rsv_ready=1, busy=0.
- Async reset: assert rst mid-cycle right after an accept -> rf_write, busy and err_underflow go 0 immediately with no clock edge, and no write is issued after reset deasserts.
